// File: rtl/sp_writeback.sv
// rtl/sp_writeback.sv - SP result writeback: 4-entry result FIFO feeding the register-file write port
//
// Purpose: accepts one SP result per sp_ack, queues it with its destination
// address and precision code, and writes it to the register file with byte
// enables derived from the precision. A warp starts on ena (thread_cnt latched
// as the target) and retires once wb_cnt reaches that target.
//
// Optional feature: define SP_WB_BYPASS_EN to let a result arriving on an
// empty FIFO drive the write port in the same cycle.
//
// Ports:
//   clk          clock, all state on the rising edge
//   Resetn       asynchronous active-low reset
//   ena          warp-start pulse (honoured in IDLE only)
//   thread_cnt   results expected for the warp
//   sp_out       SP result data
//   sp_des_addr  destination register address
//   sp_des_pre   destination precision code
//   sp_ack       SP result valid
//   rf_ready     register-file write port accepts this cycle
//   full         FIFO cannot accept a result this cycle
//   rf_we        write request
//   rf_addr      write address (0 when no request)
//   rf_data      aligned write data (0 when no request)
//   rf_be        byte enables (0 when no request)
//   busy         warp in progress
//   done         one-cycle warp-retired pulse
//   wb_cnt       results committed in the current warp
//   err          sticky error (dropped result or reserved precision)

module sp_writeback (
  input  logic        clk,
  input  logic        Resetn,
  input  logic        ena,
  input  logic [7:0]  thread_cnt,
  input  logic [31:0] sp_out,
  input  logic [8:0]  sp_des_addr,
  input  logic [2:0]  sp_des_pre,
  input  logic        sp_ack,
  input  logic        rf_ready,
  output logic        full,
  output logic        rf_we,
  output logic [8:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [3:0]  rf_be,
  output logic        busy,
  output logic        done,
  output logic [7:0]  wb_cnt,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_target;
  logic [7:0]  r_wb_cnt;
  logic        r_err;

  logic [8:0]  r_fa [4];
  logic [2:0]  r_fp [4];
  logic [31:0] r_fd [4];
  logic [2:0]  r_wptr, r_rptr;

  logic [2:0]  w_occ;
  logic        w_empty, w_active, w_start;
  logic        w_byp, w_we, w_pop, w_push, w_commit, w_drop;
  logic [8:0]  w_head_addr;
  logic [2:0]  w_head_pre;
  logic [31:0] w_head_data;
  logic [31:0] w_map_data;
  logic [3:0]  w_map_be;

  assign w_occ    = r_wptr - r_rptr;
  assign w_empty  = (w_occ == 3'd0);
  assign w_active = (r_state == S_ACTIVE);
  assign w_start  = (r_state == S_IDLE) && ena;

`ifdef SP_WB_BYPASS_EN
  assign w_byp = w_empty && w_active && sp_ack;
`else
  assign w_byp = 1'b0;
`endif

  // Head of the write port: FIFO head, or the live SP inputs when bypassing.
  assign w_head_addr = w_byp ? sp_des_addr : r_fa[r_rptr[1:0]];
  assign w_head_pre  = w_byp ? sp_des_pre  : r_fp[r_rptr[1:0]];
  assign w_head_data = w_byp ? sp_out      : r_fd[r_rptr[1:0]];

  assign w_we     = !w_empty || w_byp;
  assign w_commit = w_we && rf_ready;
  assign w_pop    = !w_empty && rf_ready;
  // A pop in this cycle frees a slot, so a simultaneous push is legal.
  assign full     = (w_occ == 3'd4) && !w_pop;
  assign w_push   = sp_ack && w_active && !full && !(w_byp && rf_ready);
  assign w_drop   = sp_ack && (!w_active || full);

  always_comb begin
    w_map_be   = 4'b1111;
    w_map_data = w_head_data;
    case (w_head_pre)
      3'b001: begin w_map_be = 4'b0011; w_map_data = {16'h0000, w_head_data[15:0]}; end
      3'b010: begin w_map_be = 4'b1100; w_map_data = {w_head_data[15:0], 16'h0000}; end
      3'b011: begin w_map_be = 4'b0001; w_map_data = {24'h000000, w_head_data[7:0]}; end
      default: begin w_map_be = 4'b1111; w_map_data = w_head_data; end
    endcase
  end

  assign rf_we   = w_we;
  assign rf_addr = w_we ? w_head_addr : 9'd0;
  assign rf_data = w_we ? w_map_data  : 32'd0;
  assign rf_be   = w_we ? w_map_be    : 4'd0;
  assign busy    = w_active;
  assign done    = (r_state == S_DONE);
  assign wb_cnt  = r_wb_cnt;
  assign err     = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ena) w_next = S_ACTIVE;
      S_ACTIVE: if (r_wb_cnt == r_target) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_target <= 8'd0;
      r_wb_cnt <= 8'd0;
      r_err    <= 1'b0;
      r_wptr   <= 3'd0;
      r_rptr   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_start) r_target <= thread_cnt;
      if (w_start) r_wb_cnt <= 8'd0;
      else if (w_commit) r_wb_cnt <= r_wb_cnt + 8'd1;
      // A warp start clears the flag, but a same-cycle error still lands.
      if (w_start) r_err <= 1'b0;
      if (w_drop || (w_commit && w_head_pre[2])) r_err <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 3'd1;
      if (w_pop)  r_rptr <= r_rptr + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wptr[1:0]] <= sp_des_addr;
      r_fp[r_wptr[1:0]] <= sp_des_pre;
      r_fd[r_wptr[1:0]] <= sp_out;
    end
  end

endmodule

// File: doc/sp_writeback.md
SP_WRITEBACK -- requirements
Module: sp_writeback

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 Resetn  input  1  asynchronous, active-low reset.
REQ-003 ena  input  1  warp-start pulse; latches thread_cnt.
REQ-004 thread_cnt  input  8  number of results expected for the warp.
REQ-005 sp_out  input  32  SP result data.
REQ-006 sp_des_addr  input  9  destination register address.
REQ-007 sp_des_pre  input  3  destination precision code.
REQ-008 sp_ack  input  1  SP result valid, one cycle per result.
REQ-009 rf_ready  input  1  register-file write port accepts this cycle.
REQ-010 full  output  1  FIFO full; SP SHALL hold its result while high.
REQ-011 rf_we  output  1  write request to register file.
REQ-012 rf_addr  output  9  write address.
REQ-013 rf_data  output  32  write data, aligned per precision.
REQ-014 rf_be  output  4  byte enables.
REQ-015 busy  output  1  high in ACTIVE.
REQ-016 done  output  1  one-cycle pulse when warp fully retired.
REQ-017 wb_cnt  output  8  results committed in the current warp.
REQ-018 err  output  1  sticky error flag.

Function
REQ-019 FSM states IDLE, ACTIVE, DONE; IDLE->ACTIVE on ena; ACTIVE->DONE when wb_cnt equals latched target; DONE->IDLE unconditionally after one cycle.
REQ-020 ena in IDLE SHALL latch thread_cnt and clear wb_cnt and err; ena in ACTIVE or DONE SHALL be ignored.
REQ-021 thread_cnt=0 SHALL go IDLE->ACTIVE->DONE with done one cycle after entering ACTIVE, no writes.
REQ-022 4-entry FIFO {addr, pre, data}, 3-bit wrapping pointers; push on sp_ack && !full in ACTIVE.
REQ-023 sp_ack while full SHALL drop the result and set err; sp_ack in IDLE or DONE SHALL drop and set err.
REQ-024 rf_we SHALL equal FIFO not-empty; commit occurs when rf_we && rf_ready; commit pops head and increments wb_cnt.
REQ-025 Simultaneous push and pop in the same cycle SHALL keep occupancy constant and be legal when full.
REQ-026 full SHALL be combinational on occupancy==4 and SHALL drop in the same cycle as a pop.
REQ-027 Precision mapping: 000 word be=1111 data unchanged; 001 half-lo be=0011 data[15:0]; 010 half-hi be=1100 data[15:0] placed at [31:16]; 011 byte be=0001 data[7:0]; 1xx reserved -> word mapping and err set at commit.
REQ-028 Without bypass, latency from sp_ack to rf_we is exactly 1 cycle.
REQ-029 done SHALL be high only in DONE; busy high only in ACTIVE.
REQ-030 wb_cnt SHALL hold its final value after DONE until next ena.

Reset
REQ-031 Resetn low SHALL asynchronously force IDLE, FIFO empty, pointers 0, full=0, rf_we=0, rf_addr=0, rf_data=0, rf_be=0, busy=0, done=0, wb_cnt=0, err=0, target=0.
REQ-032 Reset mid-warp SHALL discard FIFO contents with no further rf_we.

Configuration
REQ-033 Macro SP_WB_BYPASS_EN defined: when FIFO empty, ACTIVE and sp_ack, rf_we/rf_addr/rf_data/rf_be SHALL be driven from inputs in the same cycle; if rf_ready, commit without pushing, else push normally.
REQ-034 Macro undefined: no bypass path; all results pass through the FIFO with 1-cycle latency.

Verification
REQ-035 ena with thread_cnt=3, three sp_ack with rf_ready=1 -> three rf_we, wb_cnt=3, done pulse one cycle after third commit, busy low afterwards.
REQ-036 rf_ready=0, five consecutive sp_ack -> full high after fourth, fifth dropped, err=1; release rf_ready -> four commits in order.
REQ-037 sp_des_pre=010, sp_out=0x0000ABCD -> rf_be=1100, rf_data=0xABCD0000; pre=101 -> rf_be=1111, err=1.
REQ-038 Resetn low with 2 entries queued -> rf_we=0 immediately, wb_cnt=0, state IDLE.
REQ-039 With SP_WB_BYPASS_EN, empty FIFO, sp_ack and rf_ready=1 same cycle -> rf_we=1 that cycle, occupancy stays 0; without macro -> rf_we next cycle.
